// File: rtl/pd_seq_pkg.sv
// -----------------------------------------------------------------------------
// pd_seq_pkg
// Shared types and constants for the multi-domain power sequencer.
//   pd_state_e : per-domain sequencing state (encoding is visible on dom_state)
//   PD_STATE_W : width of one packed state field
//   settle_len : effective settle length (a setting of 0 behaves like 1)
// -----------------------------------------------------------------------------
package pd_seq_pkg;

   localparam int PD_STATE_W = 4;

   typedef enum logic [3:0] {
      OFF     = 4'd0,
      PWR_UP  = 4'd1,
      CLK_UP  = 4'd2,
      RELEASE = 4'd3,
      ON      = 4'd4,
      ISO     = 4'd5,
      CLK_DN  = 4'd6,
      PWR_DN  = 4'd7,
      FAULT   = 4'd8
   } pd_state_e;

   // A settle length of zero still costs one cycle in the state.
   function automatic int unsigned settle_len(input int unsigned cycles);
      return (cycles == 32'd0) ? 32'd1 : cycles;
   endfunction

endpackage

// File: rtl/pd_seq_fsm.sv
// -----------------------------------------------------------------------------
// pd_seq_fsm
// Sequencer for a single power domain: state register, per-step counter and
// the retention-save flop. All control outputs are decoded from the state
// register, so they change only on clk or on rst_n assertion.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req_on          level request for the domain to be on
//   req_retain      keep retention state on the next power-down
//   grant           inrush token granted to this domain (only meaningful in OFF)
//   timeout_cycles  handshake step limit, 0 disables the timeout
//   pwr_good        rail stable from the power switch
//   clk_stable      gated clock stable
//   fault_clr       clears FAULT when req_on is low
//   state           current pd_state_e
//   pwr_en, clk_en, dom_reset_n, iso_en, ret_en, dom_on, dom_busy, fault
//                   domain controls / status
//   in_pwr_up       domain currently holds the inrush token
// -----------------------------------------------------------------------------
module pd_seq_fsm
   import pd_seq_pkg::*;
#(
   parameter int TIMEOUT_W     = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_on,
   input  logic                  req_retain,
   input  logic                  grant,
   input  logic [TIMEOUT_W-1:0]  timeout_cycles,
   input  logic                  pwr_good,
   input  logic                  clk_stable,
   input  logic                  fault_clr,
   output logic [PD_STATE_W-1:0] state,
   output logic                  pwr_en,
   output logic                  clk_en,
   output logic                  dom_reset_n,
   output logic                  iso_en,
   output logic                  ret_en,
   output logic                  dom_on,
   output logic                  dom_busy,
   output logic                  fault,
   output logic                  in_pwr_up
);

   localparam int unsigned          SETTLE_EFF  = settle_len(SETTLE_CYCLES);
   localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_EFF - 32'd1);

   pd_state_e            state_r;
   pd_state_e            state_nxt_s;
   logic [TIMEOUT_W-1:0] cnt_r;
   logic                 ret_r;
   logic                 timeout_hit_s;
   logic                 settle_done_s;
   logic                 entering_s;

   // cnt_r counts cycles already spent in the current state, so the last
   // permitted cycle of a timed step is cnt_r == timeout_cycles-1.
   assign timeout_hit_s = (timeout_cycles != {TIMEOUT_W{1'b0}}) &&
                          (cnt_r == (timeout_cycles - TIMEOUT_W'(1)));
   assign settle_done_s = (cnt_r == SETTLE_LAST);
   assign entering_s    = (state_nxt_s != state_r);

   // Next-state logic; the handshake condition is tested before the timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         OFF: begin
            if (req_on && grant) state_nxt_s = PWR_UP;
            else                 state_nxt_s = OFF;
         end
         PWR_UP: begin
            if (pwr_good)           state_nxt_s = CLK_UP;
            else if (timeout_hit_s) state_nxt_s = FAULT;
            else                    state_nxt_s = PWR_UP;
         end
         CLK_UP: begin
            if (clk_stable)         state_nxt_s = RELEASE;
            else if (timeout_hit_s) state_nxt_s = FAULT;
            else                    state_nxt_s = CLK_UP;
         end
         RELEASE: begin
            if (settle_done_s) state_nxt_s = ON;
            else               state_nxt_s = RELEASE;
         end
         ON: begin
            if (!req_on) state_nxt_s = ISO;
            else         state_nxt_s = ON;
         end
         ISO: begin
            state_nxt_s = CLK_DN;
         end
         CLK_DN: begin
            if (settle_done_s) state_nxt_s = PWR_DN;
            else               state_nxt_s = CLK_DN;
         end
         PWR_DN: begin
            if (!pwr_good)          state_nxt_s = OFF;
            else if (timeout_hit_s) state_nxt_s = FAULT;
            else                    state_nxt_s = PWR_DN;
         end
         FAULT: begin
            if (fault_clr && !req_on) state_nxt_s = OFF;
            else                      state_nxt_s = FAULT;
         end
         default: begin
            // An unreachable encoding is treated as a fault: rails off, clamped.
            state_nxt_s = FAULT;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= OFF;
      else        state_r <= state_nxt_s;
   end

   // Step counter: cleared on every state change, saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           cnt_r <= {TIMEOUT_W{1'b0}};
      else if (entering_s)                  cnt_r <= {TIMEOUT_W{1'b0}};
      else if (cnt_r != {TIMEOUT_W{1'b1}})  cnt_r <= cnt_r + TIMEOUT_W'(1);
      else                                  cnt_r <= cnt_r;
   end

   // Retention save: captured on ON->ISO, held through OFF, dropped on RELEASE or FAULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       ret_r <= 1'b0;
      else if (entering_s && state_nxt_s == RELEASE)    ret_r <= 1'b0;
      else if (state_nxt_s == FAULT)                    ret_r <= 1'b0;
      else if (state_r == ON && state_nxt_s == ISO)     ret_r <= req_retain;
      else                                              ret_r <= ret_r;
   end

   // Moore output decode from the state register.
   always_comb begin
      pwr_en      = 1'b0;
      clk_en      = 1'b0;
      dom_reset_n = 1'b0;
      iso_en      = 1'b1;
      dom_on      = 1'b0;
      dom_busy    = 1'b1;
      fault       = 1'b0;
      case (state_r)
         OFF: begin
            dom_busy = 1'b0;
         end
         PWR_UP: begin
            pwr_en = 1'b1;
         end
         CLK_UP: begin
            pwr_en = 1'b1;
            clk_en = 1'b1;
         end
         RELEASE: begin
            pwr_en = 1'b1;
            clk_en = 1'b1;
            iso_en = 1'b0;
         end
         ON: begin
            pwr_en      = 1'b1;
            clk_en      = 1'b1;
            iso_en      = 1'b0;
            dom_reset_n = 1'b1;
            dom_on      = 1'b1;
            dom_busy    = 1'b0;
         end
         ISO: begin
            pwr_en = 1'b1;
            clk_en = 1'b1;
         end
         CLK_DN: begin
            pwr_en = 1'b1;
         end
         PWR_DN: begin
            pwr_en = 1'b0;
         end
         FAULT: begin
            fault    = 1'b1;
            dom_busy = 1'b0;
         end
         default: begin
            fault    = 1'b1;
            dom_busy = 1'b0;
         end
      endcase
   end

   assign ret_en    = ret_r;
   assign state     = state_r;
   assign in_pwr_up = (state_r == PWR_UP);

endmodule

// File: rtl/power_domain_sequencer.sv
// -----------------------------------------------------------------------------
// power_domain_sequencer
// Drives NUM_DOMAINS gated domains through ordered power-up/down sequences
// (rail, clock, isolation, retention, reset). An inrush limiter lets at most
// one domain ramp its rail at a time; power-down is never throttled.
// Ports (all per-domain vectors are NUM_DOMAINS wide, bit i = domain i):
//   clk, rst_n            clock, async active-low reset
//   req_on, req_retain    power manager requests
//   timeout_cycles        handshake step limit, 0 = no timeout
//   pwr_good, clk_stable  switch / clock gate feedback
//   fault_clr             clears FAULT for domains whose req_on is low
//   pwr_en, clk_en, dom_reset_n, iso_en, ret_en   domain controls
//   dom_on, dom_busy, fault                        domain status
//   dom_state             packed pd_state_e, domain i at [4i+3:4i]
// -----------------------------------------------------------------------------
module power_domain_sequencer
   import pd_seq_pkg::*;
#(
   parameter int NUM_DOMAINS   = 4,
   parameter int TIMEOUT_W     = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_DOMAINS-1:0]            req_on,
   input  logic [NUM_DOMAINS-1:0]            req_retain,
   input  logic [TIMEOUT_W-1:0]              timeout_cycles,
   input  logic [NUM_DOMAINS-1:0]            pwr_good,
   input  logic [NUM_DOMAINS-1:0]            clk_stable,
   input  logic [NUM_DOMAINS-1:0]            fault_clr,
   output logic [NUM_DOMAINS-1:0]            pwr_en,
   output logic [NUM_DOMAINS-1:0]            clk_en,
   output logic [NUM_DOMAINS-1:0]            dom_reset_n,
   output logic [NUM_DOMAINS-1:0]            iso_en,
   output logic [NUM_DOMAINS-1:0]            ret_en,
   output logic [NUM_DOMAINS-1:0]            dom_on,
   output logic [NUM_DOMAINS-1:0]            dom_busy,
   output logic [NUM_DOMAINS-1:0]            fault,
   output logic [PD_STATE_W*NUM_DOMAINS-1:0] dom_state
);

   logic [NUM_DOMAINS-1:0] in_pwr_up_s;
   logic [NUM_DOMAINS-1:0] cand_s;
   logic [NUM_DOMAINS-1:0] grant_s;

   // Domains sitting in OFF with an on-request compete for the token.
   always_comb begin
      cand_s = {NUM_DOMAINS{1'b0}};
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         cand_s[i] = req_on[i] && (dom_state[PD_STATE_W*i +: PD_STATE_W] == OFF);
      end
   end

   // Lowest-index candidate wins, and only while no domain is ramping its rail.
   always_comb begin
      if (in_pwr_up_s == {NUM_DOMAINS{1'b0}}) grant_s = cand_s & (~cand_s + NUM_DOMAINS'(1));
      else                                    grant_s = {NUM_DOMAINS{1'b0}};
   end

   for (genvar g = 0; g < NUM_DOMAINS; g++) begin : gen_dom
      pd_seq_fsm #(
         .TIMEOUT_W     (TIMEOUT_W),
         .SETTLE_CYCLES (SETTLE_CYCLES)
      ) u_fsm (
         .clk            (clk),
         .rst_n          (rst_n),
         .req_on         (req_on[g]),
         .req_retain     (req_retain[g]),
         .grant          (grant_s[g]),
         .timeout_cycles (timeout_cycles),
         .pwr_good       (pwr_good[g]),
         .clk_stable     (clk_stable[g]),
         .fault_clr      (fault_clr[g]),
         .state          (dom_state[PD_STATE_W*g +: PD_STATE_W]),
         .pwr_en         (pwr_en[g]),
         .clk_en         (clk_en[g]),
         .dom_reset_n    (dom_reset_n[g]),
         .iso_en         (iso_en[g]),
         .ret_en         (ret_en[g]),
         .dom_on         (dom_on[g]),
         .dom_busy       (dom_busy[g]),
         .fault          (fault[g]),
         .in_pwr_up      (in_pwr_up_s[g])
      );
   end

endmodule
